eth_frame_cmd_decoder: RTL and testbench

Byte-stream command decoder sitting directly downstream of the UDP receive FIFO (`fifo_rx`, read side on the 50 MHz domain) and upstream of the command register bank. Pulls payload bytes from the FIFO, locates framed commands, validates them and emits one `cmdvalid` pulse with an 8-bit register address and 32-bit data per good frame. Malformed or stalled frames are dropped, counted and reported.

---
 rtl/eth_cmd_pkg.sv | 33 +++
 rtl/frame_timeout_cnt.sv | 38 +++
 rtl/eth_frame_cmd_decoder.sv | 173 +++++++++++++++++
 tb/tb_eth_frame_cmd_decoder.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_cmd_pkg.sv
// eth_cmd_pkg: shared constants, FSM state encoding and checksum helper
// for the framed command decoder (optional feature: ETH_CMD_CHECKSUM_EN).
package eth_cmd_pkg;

    localparam logic [7:0] DEF_HDR0 = 8'h55;
    localparam logic [7:0] DEF_HDR1 = 8'hA5;
    localparam logic [7:0] DEF_TAIL = 8'hF0;
    localparam int unsigned DEF_TIMEOUT_CYC = 50000;

`ifdef ETH_CMD_CHECKSUM_EN
    localparam int unsigned FRAME_LEN = 9;
`else
    localparam int unsigned FRAME_LEN = 8;
`endif

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HDR1 = 3'd1,
        S_ADDR = 3'd2,
        S_DATA = 3'd3,
`ifdef ETH_CMD_CHECKSUM_EN
        S_CSUM = 3'd4,
`endif
        S_TAIL = 3'd5
    } state_e;

    // 8-bit wrap-around sum of the address and the four data bytes.
    function automatic logic [7:0] csum8(input logic [7:0]  a,
                                         input logic [31:0] d);
        return a + d[31:24] + d[23:16] + d[15:8] + d[7:0];
    endfunction

endpackage

// File: rtl/frame_timeout_cnt.sv
// frame_timeout_cnt: idle-cycle watchdog. Ports: clk, reset_n (async low),
// clr_i (restart), en_i (count enable), expire_o (pulse when limit reached).
module frame_timeout_cnt #(
    parameter int unsigned TIMEOUT_CYC = 50000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int W = ($clog2(TIMEOUT_CYC) > 16) ?
                       $clog2(TIMEOUT_CYC) : 16;

    logic [W-1:0] cnt_q, cnt_d;

    // cnt_q holds idle cycles already elapsed before this one, so the
    // limit is hit on the TIMEOUT_CYC-th idle cycle; a clear wins.
    assign expire_o = en_i & ~clr_i &
                      (cnt_q == W'(TIMEOUT_CYC - 1));

    always_comb begin
        cnt_d = cnt_q + W'(1);
        if (clr_i || !en_i || expire_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/eth_frame_cmd_decoder.sv
// eth_frame_cmd_decoder: pulls bytes from the rx FIFO, decodes
// HDR0 HDR1 ADDR D3..D0 [CSUM] TAIL frames into cmd_addr/cmd_data with a
// cmdvalid pulse; bad or stalled frames pulse frame_err and bump err_cnt.
// Ports: clk, reset_n, rx_empty, fifo_rd_req, fifodout, cmdvalid,
// cmd_addr, cmd_data, frame_err, err_cnt. Option: ETH_CMD_CHECKSUM_EN.
module eth_frame_cmd_decoder
    import eth_cmd_pkg::*;
#(
    parameter logic [7:0]  HDR0        = DEF_HDR0,
    parameter logic [7:0]  HDR1        = DEF_HDR1,
    parameter logic [7:0]  TAIL        = DEF_TAIL,
    parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        rx_empty,
    output logic        fifo_rd_req,
    input  logic [7:0]  fifodout,
    output logic        cmdvalid,
    output logic [7:0]  cmd_addr,
    output logic [31:0] cmd_data,
    output logic        frame_err,
    output logic [15:0] err_cnt
);

    state_e      state_q, state_d;
    logic        byte_vld_q;
    logic [1:0]  cnt_q, cnt_d;
    logic [7:0]  addr_sh_q, addr_sh_d;
    logic [31:0] data_sh_q, data_sh_d;
    logic [7:0]  cmd_addr_q, cmd_addr_d;
    logic [31:0] cmd_data_q, cmd_data_d;
    logic        cmdvalid_q, cmdvalid_d;
    logic        frame_err_q, frame_err_d;
    logic [15:0] err_cnt_q, err_cnt_d;
    logic        tmo_expire;
    logic        drop;
    logic        tail_ok;
`ifdef ETH_CMD_CHECKSUM_EN
    logic        fault_q, fault_d;
`endif

    assign fifo_rd_req = ~rx_empty & reset_n;

    frame_timeout_cnt #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_tmo (
        .clk      (clk),
        .reset_n  (reset_n),
        .clr_i    (byte_vld_q),
        .en_i     (state_q != S_IDLE),
        .expire_o (tmo_expire)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_sh_d   = addr_sh_q;
        data_sh_d   = data_sh_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_data_d  = cmd_data_q;
        cmdvalid_d  = 1'b0;
        frame_err_d = 1'b0;
        err_cnt_d   = err_cnt_q;
        drop        = 1'b0;
        tail_ok     = 1'b0;
`ifdef ETH_CMD_CHECKSUM_EN
        fault_d     = fault_q;
`endif
        if (byte_vld_q) begin
            unique case (state_q)
                S_IDLE: begin
                    if (fifodout == HDR0) state_d = S_HDR1;
                end
                S_HDR1: begin
                    if (fifodout == HDR1) begin
                        state_d = S_ADDR;
                    end else if (fifodout != HDR0) begin
                        state_d = S_IDLE;
                    end
                end
                S_ADDR: begin
                    addr_sh_d = fifodout;
                    cnt_d     = 2'd0;
                    state_d   = S_DATA;
`ifdef ETH_CMD_CHECKSUM_EN
                    fault_d   = 1'b0;
`endif
                end
                S_DATA: begin
                    data_sh_d = {data_sh_q[23:0], fifodout};
                    cnt_d     = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
`ifdef ETH_CMD_CHECKSUM_EN
                        state_d = S_CSUM;
`else
                        state_d = S_TAIL;
`endif
                    end
                end
`ifdef ETH_CMD_CHECKSUM_EN
                S_CSUM: begin
                    fault_d = (fifodout != csum8(addr_sh_q, data_sh_q));
                    state_d = S_TAIL;
                end
`endif
                S_TAIL: begin
                    tail_ok = (fifodout == TAIL);
`ifdef ETH_CMD_CHECKSUM_EN
                    tail_ok = tail_ok & ~fault_q;
`endif
                    if (tail_ok) begin
                        cmd_addr_d = addr_sh_q;
                        cmd_data_d = data_sh_q;
                        cmdvalid_d = 1'b1;
                    end else begin
                        drop = 1'b1;
                    end
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end else if (tmo_expire) begin
            drop      = 1'b1;
            state_d   = S_IDLE;
            addr_sh_d = '0;
            data_sh_d = '0;
        end
        if (drop) begin
            frame_err_d = 1'b1;
            if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            byte_vld_q  <= 1'b0;
            cnt_q       <= '0;
            addr_sh_q   <= '0;
            data_sh_q   <= '0;
            cmd_addr_q  <= '0;
            cmd_data_q  <= '0;
            cmdvalid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            err_cnt_q   <= '0;
`ifdef ETH_CMD_CHECKSUM_EN
            fault_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            byte_vld_q  <= fifo_rd_req;
            cnt_q       <= cnt_d;
            addr_sh_q   <= addr_sh_d;
            data_sh_q   <= data_sh_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_data_q  <= cmd_data_d;
            cmdvalid_q  <= cmdvalid_d;
            frame_err_q <= frame_err_d;
            err_cnt_q   <= err_cnt_d;
`ifdef ETH_CMD_CHECKSUM_EN
            fault_q     <= fault_d;
`endif
        end
    end

    assign cmdvalid  = cmdvalid_q;
    assign frame_err = frame_err_q;
    assign cmd_addr  = cmd_addr_q;
    assign cmd_data  = cmd_data_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_eth_frame_cmd_decoder.sv
// tb_eth_frame_cmd_decoder: directed vectors for the frame command decoder;
// works with or without ETH_CMD_CHECKSUM_EN.
module tb_eth_frame_cmd_decoder;

`ifdef ETH_CMD_CHECKSUM_EN
    localparam int FLEN = 9;
`else
    localparam int FLEN = 8;
`endif
    localparam int TMO = 50000;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        rx_empty;
    logic        fifo_rd_req;
    logic [7:0]  fifodout;
    logic        cmdvalid;
    logic [7:0]  cmd_addr;
    logic [31:0] cmd_data;
    logic        frame_err;
    logic [15:0] err_cnt;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int nvalid = 0;
    int last_v = 0;
    int prev_v = 0;
    int both = 0;

    logic [7:0] txq[$];

    eth_frame_cmd_decoder dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .rx_empty    (rx_empty),
        .fifo_rd_req (fifo_rd_req),
        .fifodout    (fifodout),
        .cmdvalid    (cmdvalid),
        .cmd_addr    (cmd_addr),
        .cmd_data    (cmd_data),
        .frame_err   (frame_err),
        .err_cnt     (err_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (cmdvalid === 1'b1) begin
            nvalid <= nvalid + 1;
            prev_v <= last_v;
            last_v <= cyc;
        end
        if (cmdvalid === 1'b1 && frame_err === 1'b1) both <= both + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_raw(input logic [7:0] b);
        txq.push_back(b);
    endtask

    task automatic push_frame(input logic [7:0] a, input logic [31:0] d,
                              input logic [7:0] t);
        logic [7:0] s;
        s = a + d[31:24] + d[23:16] + d[15:8] + d[7:0];
        txq.push_back(8'h55);
        txq.push_back(8'hA5);
        txq.push_back(a);
        txq.push_back(d[31:24]);
        txq.push_back(d[23:16]);
        txq.push_back(d[15:8]);
        txq.push_back(d[7:0]);
`ifdef ETH_CMD_CHECKSUM_EN
        txq.push_back(s);
`else
        s = 8'h00;
`endif
        txq.push_back(t);
    endtask

    // Read request in cycle i, data presented in cycle i+1. Returns at the
    // negedge of the cycle in which the last byte is on fifodout.
    task automatic stream();
        int n;
        n = txq.size();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rx_empty = 1'b0;
            if (i > 0) fifodout = txq[i-1];
        end
        @(negedge clk);
        rx_empty = 1'b1;
        fifodout = txq[n-1];
        txq.delete();
    endtask

    task automatic expect_good(input string tag, input logic [7:0] a,
                               input logic [31:0] d, input logic [15:0] e);
        check({tag, "_early"}, {31'd0, cmdvalid}, 32'd0);
        @(negedge clk);
        check({tag, "_valid"}, {31'd0, cmdvalid}, 32'd1);
        check({tag, "_noerr"}, {31'd0, frame_err}, 32'd0);
        check({tag, "_addr"}, {24'd0, cmd_addr}, {24'd0, a});
        check({tag, "_data"}, cmd_data, d);
        check({tag, "_errcnt"}, {16'd0, err_cnt}, {16'd0, e});
        @(negedge clk);
        check({tag, "_pulse"}, {31'd0, cmdvalid}, 32'd0);
    endtask

    task automatic expect_drop(input string tag, input logic [7:0] a,
                               input logic [31:0] d, input logic [15:0] e);
        @(negedge clk);
        check({tag, "_err"}, {31'd0, frame_err}, 32'd1);
        check({tag, "_novalid"}, {31'd0, cmdvalid}, 32'd0);
        check({tag, "_addr"}, {24'd0, cmd_addr}, {24'd0, a});
        check({tag, "_data"}, cmd_data, d);
        check({tag, "_errcnt"}, {16'd0, err_cnt}, {16'd0, e});
        @(negedge clk);
        check({tag, "_pulse"}, {31'd0, frame_err}, 32'd0);
    endtask

    initial begin
        int base;
        reset_n  = 1'b0;
        rx_empty = 1'b1;
        fifodout = 8'h00;
        repeat (3) @(negedge clk);
        rx_empty = 1'b0;
        #1;
        check("rst_rdreq", {31'd0, fifo_rd_req}, 32'd0);
        check("rst_valid", {31'd0, cmdvalid}, 32'd0);
        check("rst_err", {31'd0, frame_err}, 32'd0);
        check("rst_addr", {24'd0, cmd_addr}, 32'd0);
        check("rst_data", cmd_data, 32'd0);
        check("rst_errcnt", {16'd0, err_cnt}, 32'd0);
        rx_empty = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        #1;
        check("rdreq_empty", {31'd0, fifo_rd_req}, 32'd0);
        rx_empty = 1'b0;
        #1;
        check("rdreq_avail", {31'd0, fifo_rd_req}, 32'd1);
        rx_empty = 1'b1;

        // Basic frame
        push_frame(8'h03, 32'h0000_01F4, 8'hF0);
        stream();
        expect_good("basic", 8'h03, 32'h0000_01F4, 16'd0);

        // Leading garbage and a repeated HDR0 resync
        push_raw(8'h00);
        push_raw(8'h55);
        push_frame(8'h12, 32'hDEAD_BEEF, 8'hF0);
        stream();
        expect_good("resync", 8'h12, 32'hDEAD_BEEF, 16'd0);

        // Wrong trailer is dropped, outputs untouched
        push_frame(8'h34, 32'hCAFE_BABE, 8'h0F);
        stream();
        expect_drop("badtail", 8'h12, 32'hDEAD_BEEF, 16'd1);

        // Two frames with no gap
        base = nvalid;
        push_frame(8'h21, 32'h0102_0304, 8'hF0);
        push_frame(8'h22, 32'hA0B0_C0D0, 8'hF0);
        stream();
        expect_good("b2b", 8'h22, 32'hA0B0_C0D0, 16'd1);
        @(negedge clk);
        check("b2b_count", nvalid - base, 32'd2);
        check("b2b_spacing", last_v - prev_v, FLEN);

        // Header mismatch after HDR0: silent, no error
        push_raw(8'h55);
        push_raw(8'h3C);
        push_frame(8'h41, 32'h0BAD_F00D, 8'hF0);
        stream();
        expect_good("hdrmis", 8'h41, 32'h0BAD_F00D, 16'd1);

        // Stall after ADDR until the watchdog fires
        push_raw(8'h55);
        push_raw(8'hA5);
        push_raw(8'h03);
        stream();
        repeat (TMO) @(negedge clk);
        check("tmo_notyet", {31'd0, frame_err}, 32'd0);
        expect_drop("tmo", 8'h41, 32'h0BAD_F00D, 16'd2);
        push_frame(8'h40, 32'h1234_5678, 8'hF0);
        stream();
        expect_good("post_tmo", 8'h40, 32'h1234_5678, 16'd2);

`ifdef ETH_CMD_CHECKSUM_EN
        foreach (txq[i]) txq[i] = 8'h00;
        push_raw(8'h55); push_raw(8'hA5); push_raw(8'h01);
        push_raw(8'h00); push_raw(8'h00); push_raw(8'h00);
        push_raw(8'h02); push_raw(8'h03); push_raw(8'hF0);
        stream();
        expect_good("csum_ok", 8'h01, 32'h0000_0002, 16'd2);
        push_raw(8'h55); push_raw(8'hA5); push_raw(8'h01);
        push_raw(8'h00); push_raw(8'h00); push_raw(8'h00);
        push_raw(8'h02); push_raw(8'h04); push_raw(8'hF0);
        stream();
        expect_drop("csum_bad", 8'h01, 32'h0000_0002, 16'd3);
`endif

        // Reset in the middle of the data bytes
        push_raw(8'h55);
        push_raw(8'hA5);
        push_raw(8'h07);
        push_raw(8'h11);
        push_raw(8'h22);
        stream();
        reset_n  = 1'b0;
        rx_empty = 1'b0;
        #1;
        check("mrst_rdreq", {31'd0, fifo_rd_req}, 32'd0);
        check("mrst_addr", {24'd0, cmd_addr}, 32'd0);
        check("mrst_data", cmd_data, 32'd0);
        check("mrst_errcnt", {16'd0, err_cnt}, 32'd0);
        rx_empty = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        push_frame(8'h09, 32'h0000_0009, 8'hF0);
        stream();
        expect_good("post_rst", 8'h09, 32'h0000_0009, 16'd0);

        repeat (2) @(negedge clk);
        check("exclusive", both, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
